// File: rtl/vending_controller.sv
// -----------------------------------------------------------------------------
// vending_controller
//
// Coin-operated vending controller. It accepts nickel, dime and quarter pulses
// and vends once the accumulated credit reaches PRICE. Change (or a refund on
// cancel) is returned one coin per cycle, choosing coins greedily.
// It tracks stock, flags sold-out, and refuses illegal or untimely coins.
//
// Parameters
//   PRICE       product price in cents (multiple of 5, >= 5)
//   STOCK_INIT  items loaded at reset and on restock (>= 1)
//   CREDIT_W    width of credit/change registers (must hold PRICE+20)
//   STOCK_W     width of the stock counter (must hold STOCK_INIT)
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   nickle_i         5-cent coin present
//   dime_i           10-cent coin present
//   quarter_i        25-cent coin present
//   cancel_i         refund request
//   restock_i        reload stock to STOCK_INIT (honoured in IDLE only)
//   soda_o           one-cycle vend pulse
//   coin_nickle_o    returning a nickel this cycle
//   coin_dime_o      returning a dime this cycle
//   coin_quarter_o   returning a quarter this cycle
//   reject_o         one-cycle pulse: last sampled coin refused
//   sold_out_o       stock is zero
//   busy_o           vending or returning change
//   credit_o         accepted credit in cents
// -----------------------------------------------------------------------------
module vending_controller #(
  parameter int unsigned PRICE      = 20,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned CREDIT_W   = 7,
  parameter int unsigned STOCK_W    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quarter_i,
  input  logic                cancel_i,
  input  logic                restock_i,
  output logic                soda_o,
  output logic                coin_nickle_o,
  output logic                coin_dime_o,
  output logic                coin_quarter_o,
  output logic                reject_o,
  output logic                sold_out_o,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W-1:0] VAL_N      = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] VAL_D      = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] VAL_Q      = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(STOCK_INIT);

  state_t              state;
  logic [CREDIT_W-1:0] rem;    // change still owed after the coin currently on the outputs
  logic [STOCK_W-1:0]  stock;

  // Largest coin not exceeding the amount still owed.
  function automatic logic [CREDIT_W-1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= VAL_Q)      return VAL_Q;
    else if (amt >= VAL_D) return VAL_D;
    else                   return VAL_N;
  endfunction

  // {quarter, dime, nickel} output pattern for a coin value.
  function automatic logic [2:0] coin_onehot(input logic [CREDIT_W-1:0] v);
    return {v == VAL_Q, v == VAL_D, v == VAL_N};
  endfunction

  logic [1:0]          coin_cnt;
  logic                coin_seen;
  logic                coin_multi;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] refund_coin;
  logic [CREDIT_W-1:0] change_coin;
  logic                vend_now;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    coin_val = '0;
    if (quarter_i)     coin_val = VAL_Q;
    else if (dime_i)   coin_val = VAL_D;
    else if (nickle_i) coin_val = VAL_N;

    coin_cnt    = {1'b0, nickle_i} + {1'b0, dime_i} + {1'b0, quarter_i};
    coin_seen   = coin_cnt != 2'd0;
    coin_multi  = coin_cnt > 2'd1;
    credit_sum  = credit_o + coin_val;
    refund_coin = greedy_coin(credit_o);
    change_coin = greedy_coin(rem);
    vend_now    = (state == IDLE) && !cancel_i && coin_seen && !coin_multi &&
                  !sold_out_o && (credit_sum >= PRICE_C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      credit_o       <= '0;
      rem            <= '0;
      stock          <= STOCK_FULL;
      soda_o         <= 1'b0;
      coin_nickle_o  <= 1'b0;
      coin_dime_o    <= 1'b0;
      coin_quarter_o <= 1'b0;
      reject_o       <= 1'b0;
      sold_out_o     <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in
      // the same block, which is what makes the pulse outputs last one cycle.
      soda_o                                       <= 1'b0;
      {coin_quarter_o, coin_dime_o, coin_nickle_o} <= 3'b000;
      reject_o                                     <= 1'b0;

      unique case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (cancel_i) begin
            // Cancel wins over any coin on the same edge.
            reject_o <= coin_seen;
            if (credit_o != '0) begin
              // The first refund coin goes out in the very first CHANGE cycle.
              state    <= CHANGE;
              busy_o   <= 1'b1;
              credit_o <= '0;
              rem      <= credit_o - refund_coin;
              {coin_quarter_o, coin_dime_o, coin_nickle_o} <= coin_onehot(refund_coin);
            end
          end else if (coin_seen) begin
            if (coin_multi || sold_out_o) begin
              reject_o <= 1'b1;
            end else if (vend_now) begin
              state    <= VEND;
              busy_o   <= 1'b1;
              soda_o   <= 1'b1;
              credit_o <= '0;
              rem      <= credit_sum - PRICE_C;
            end else begin
              credit_o <= credit_sum;
            end
          end

          if (restock_i) begin
            stock      <= STOCK_FULL;
            sold_out_o <= 1'b0;
          end else if (vend_now) begin
            stock      <= stock - STOCK_W'(1);
            sold_out_o <= (stock == STOCK_W'(1));
          end
        end

        VEND, CHANGE: begin
          reject_o <= coin_seen;
          if (rem != '0) begin
            state  <= CHANGE;
            busy_o <= 1'b1;
            rem    <= rem - change_coin;
            {coin_quarter_o, coin_dime_o, coin_nickle_o} <= coin_onehot(change_coin);
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
